rf_wr_sched: RTL and testbench
==============================

RF_WR_SCHED -- requirements
Module: rf_wr_sched

Interface
REQ-001 Parameter INIT_VALUE, default 4'h0, value written to every entry during initialisation.
REQ-002 Parameter NUM_ENTRIES, default 8, number of register-file entries; address width is 3.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 init_req  input  1  pulse; re-run initialisation.
REQ-006 req0_valid / req1_valid  input  1  write request from requester 0 / 1.
REQ-007 req0_addr / req1_addr  input  3  target entry.
REQ-008 req0_data / req1_data  input  4  write data.
REQ-009 req0_ready / req1_ready  output  1  combinational grant; a transfer occurs when valid and ready are both 1.
REQ-010 w_wr  output  1  register-file write strobe, registered.
REQ-011 w_addr  output  3  register-file write address, registered.
REQ-012 w_data  output  4  register-file write data, registered.
REQ-013 init_busy  output  1  1 while in INIT, registered.
REQ-014 last_grant  output  1  index of the most recently granted requester, registered.

Function
REQ-015 The block SHALL have two states: INIT and ARB.
REQ-016 In INIT, the block SHALL drive one write per cycle, w_wr=1, w_data=INIT_VALUE, w_addr=0,1,...,NUM_ENTRIES-1, and enter ARB after address NUM_ENTRIES-1 is issued.
REQ-017 init_busy SHALL be 1 on every cycle w_wr carries an INIT write and SHALL be 0 from the first ARB cycle.
REQ-018 In INIT, req0_ready and req1_ready SHALL both be 0.
REQ-019 In ARB with one valid request, the block SHALL assert ready only to that requester.
REQ-020 In ARB with both valid, the block SHALL grant the requester not equal to last_grant (round-robin).
REQ-021 At most one ready SHALL be 1 in any cycle.
REQ-022 A transfer accepted in cycle N SHALL appear on w_wr/w_addr/w_data in cycle N+1 (latency 1); w_wr SHALL be 0 in ARB cycles following a cycle with no transfer.
REQ-023 last_grant SHALL update in the cycle after a transfer; it SHALL be unchanged when there is no transfer.
REQ-024 Requesters SHALL hold valid, addr, and data stable until ready; the block SHALL NOT buffer more than one write.
REQ-025 Back-to-back transfers SHALL be supported at one write per cycle with no bubble.
REQ-026 Same-address writes from both requesters SHALL be serialised in grant order, so the later grant's data persists.
REQ-027 init_req=1 in ARB SHALL force both readies to 0 in that cycle and enter INIT at address 0 next cycle; a write accepted in the previous cycle SHALL still issue.
REQ-028 init_req in INIT SHALL be ignored; the sequence SHALL NOT restart.
REQ-029 The address counter SHALL saturate at NUM_ENTRIES-1 and SHALL NOT wrap into a ninth write.

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL enter INIT with the counter at 0, w_wr=0, w_addr=0, w_data=0, init_busy=1, and last_grant=1, so requester 0 wins the first contention.
REQ-031 The first INIT write SHALL occur in the first cycle after rst returns to 1.
REQ-032 Reset asserted mid-INIT or mid-ARB SHALL abandon the current operation and restart INIT from address 0.

Structure
REQ-033 A shared package SHALL hold the state enum (INIT, ARB) and the address-width and data-width constants (3, 4).
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arb2 (two requests, last-grant input, one-hot grant output).
REQ-035 The block SHALL connect to rf_8x4_2r1w write ports w_wr, w_addr, and w_data without glue logic.

Verification
REQ-036 Reset release -> w_wr=1 for 8 cycles with w_addr 0..7 and w_data=0, init_busy falls after addr 7, readies are 0 throughout.
REQ-037 After INIT, req0 writes addr 3, data 4'hA -> req0_ready=1 that cycle; the next cycle shows w_wr=1, w_addr=3, w_data=A, last_grant=0.
REQ-038 Both valid for 4 cycles (req0 addr1/data5, req1 addr2/data6, held) -> grants alternate 0,1,0,1 and writes issue every cycle.
REQ-039 Both write addr 4 (req0 data 1, req1 data 2) with last_grant=1 -> req0 is granted first, and a readback of addr 4 returns 2.
REQ-040 init_req pulse while req1 is valid -> req1_ready=0, and the next 8 cycles re-clear addresses 0..7.
REQ-041 rst=0 at INIT address 5 -> outputs take reset values, and INIT restarts at address 0 after release.

Source files
------------

// File: rtl/rf_wr_sched_pkg.sv
// rtl/rf_wr_sched_pkg.sv - shared types and widths for the register-file write scheduler
package rf_wr_sched_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

endpackage

// File: rtl/rf_wr_sched_rr_arb2.sv
// rtl/rf_wr_sched_rr_arb2.sv - two-way round-robin arbiter
//
// Ports:
//   req  [1:0]  request vector (bit i = requester i)
//   last        index of the most recently granted requester
//   gnt  [1:0]  one-hot grant (all zero when nothing requests)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Under contention the requester that did not win last time gets the grant.
    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/rf_wr_sched.sv
// rtl/rf_wr_sched.sv - initialises a register file, then arbitrates two write requesters onto its write port
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   init_req                  pulse: clear the register file again (ignored while clearing)
//   req0_* / req1_*           valid/addr/data write requests with combinational ready
//   w_wr, w_addr, w_data      registered register-file write port
//   init_busy                 registered, 1 while clearing writes are on the write port
//   last_grant                registered index of the most recently granted requester
module rf_wr_sched
    import rf_wr_sched_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE  = 4'h0,
    parameter int                NUM_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              w_wr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              init_busy,
    output logic              last_grant
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              arb_en;
    logic [1:0]        gnt;
    logic              xfer;

    rr_arb2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last_grant),
        .gnt  (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter saturates on the last entry; it only returns to zero when
    // a new clearing pass starts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        arb_en    = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_ARB;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ARB: begin
                if (init_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end else begin
                    arb_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign req0_ready = arb_en & gnt[0];
    assign req1_ready = arb_en & gnt[1];
    assign xfer       = req0_ready | req1_ready;

    // Write port and status are registered so the register file sees a clean
    // one-cycle-late copy of whatever was issued or accepted this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_wr       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            init_busy  <= 1'b1;
            last_grant <= 1'b1;
        end else if (state == ST_INIT) begin
            w_wr      <= 1'b1;
            w_addr    <= cnt;
            w_data    <= INIT_VALUE;
            init_busy <= 1'b1;
        end else begin
            init_busy <= 1'b0;
            w_wr      <= xfer;
            if (xfer) begin
                w_addr     <= req1_ready ? req1_addr : req0_addr;
                w_data     <= req1_ready ? req1_data : req0_data;
                last_grant <= req1_ready;
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_sched.sv
// tb/tb_rf_wr_sched.sv - self-checking bench for rf_wr_sched
module tb_rf_wr_sched;

    logic       clk;
    logic       rst;
    logic       init_req;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [3:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [3:0] req1_data;
    logic       req1_ready;
    logic       w_wr;
    logic [2:0] w_addr;
    logic [3:0] w_data;
    logic       init_busy;
    logic       last_grant;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    rf_wr_sched dut (
        .clk        (clk),
        .rst        (rst),
        .init_req   (init_req),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .w_wr       (w_wr),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .init_busy  (init_busy),
        .last_grant (last_grant)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: where the clearing pass is, who won last, and what the
    // write port must show. Updated once per cycle from the inputs present
    // just before the rising edge.
    bit       m_clearing = 1;
    int       m_idx      = 0;
    bit       m_last     = 1;
    bit       e_wr       = 0;
    int       e_addr     = 0;
    int       e_data     = 0;
    bit       e_busy     = 1;
    logic [3:0] mem [8];

    always @(negedge clk) begin
        int g;
        g = -1;
        if (!m_clearing && !init_req) begin
            if (req0_valid && req1_valid) g = m_last ? 0 : 1;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        if (chk_en) begin
            chk("w_wr", int'(w_wr), int'(e_wr));
            if (e_wr) begin
                chk("w_addr", int'(w_addr), e_addr);
                chk("w_data", int'(w_data), e_data);
            end
            chk("init_busy", int'(init_busy), int'(e_busy));
            chk("last_grant", int'(last_grant), int'(m_last));
            chk("req0_ready", int'(req0_ready), int'(g == 0));
            chk("req1_ready", int'(req1_ready), int'(g == 1));
        end
        if (w_wr === 1'b1) mem[w_addr] = w_data;
        if (!rst) begin
            m_clearing = 1; m_idx = 0; m_last = 1;
            e_wr = 0; e_addr = 0; e_data = 0; e_busy = 1;
        end else if (m_clearing) begin
            e_wr = 1; e_addr = m_idx; e_data = 0; e_busy = 1;
            if (m_idx == 7) m_clearing = 0;
            else            m_idx++;
        end else begin
            e_busy = 0;
            if (init_req) begin
                e_wr = 0; m_clearing = 1; m_idx = 0;
            end else if (g >= 0) begin
                e_wr   = 1;
                e_addr = (g == 1) ? int'(req1_addr) : int'(req0_addr);
                e_data = (g == 1) ? int'(req1_data) : int'(req0_data);
                m_last = (g == 1);
            end else begin
                e_wr = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wr"},   int'(w_wr), 0);
        chk({tag, "_addr"}, int'(w_addr), 0);
        chk({tag, "_data"}, int'(w_data), 0);
        chk({tag, "_busy"}, int'(init_busy), 1);
        chk({tag, "_last"}, int'(last_grant), 1);
    endtask

    initial begin
        bit acc0, acc1;
        rst = 0; init_req = 0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        step();
        chk_en = 1;
        step();
        chk_reset_vals("rst");

        // Clearing pass after reset release
        rst = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("init_wr", int'(w_wr), 1);
            chk("init_addr", int'(w_addr), i);
            chk("init_data", int'(w_data), 0);
            chk("init_busy_hi", int'(init_busy), 1);
            chk("init_rdy", int'({req1_ready, req0_ready}), 0);
        end
        step();
        chk("busy_fall", int'(init_busy), 0);
        chk("idle_wr", int'(w_wr), 0);

        // Single write from requester 0
        req0_valid = 1; req0_addr = 3; req0_data = 4'hA;
        #1 chk("single_rdy0", int'(req0_ready), 1);
        step();
        req0_valid = 0;
        chk("single_wr", int'(w_wr), 1);
        chk("single_addr", int'(w_addr), 3);
        chk("single_data", int'(w_data), 10);
        chk("single_last", int'(last_grant), 0);

        // One write from requester 1, then both contend for four cycles
        req1_valid = 1; req1_addr = 2; req1_data = 6;
        step();
        req0_valid = 1; req0_addr = 1; req0_data = 5;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_rdy0", int'(req0_ready), int'(k % 2 == 0));
            step();
            chk("rr_wr", int'(w_wr), 1);
            chk("rr_addr", int'(w_addr), (k % 2 == 0) ? 1 : 2);
        end
        req0_valid = 0; req1_valid = 0;

        // Same address from both; later grant's data must persist
        req0_valid = 1; req0_addr = 4; req0_data = 1;
        req1_valid = 1; req1_addr = 4; req1_data = 2;
        #1 chk("same_rdy0", int'(req0_ready), 1);
        step();
        req0_valid = 0;
        chk("same_first", int'(w_data), 1);
        #1 chk("same_rdy1", int'(req1_ready), 1);
        step();
        req1_valid = 0;
        chk("same_second", int'(w_data), 2);
        step();
        chk("readback4", int'(mem[4]), 2);
        chk("readback3", int'(mem[3]), 10);

        // init_req while requester 1 is waiting; a second pulse mid-pass is ignored
        req1_valid = 1; req1_addr = 6; req1_data = 7; init_req = 1;
        #1 chk("initreq_rdy1", int'(req1_ready), 0);
        step();
        init_req = 0; req1_valid = 0;
        chk("initreq_nowr", int'(w_wr), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            init_req = 0;
            chk("reinit_addr", int'(w_addr), i);
            chk("reinit_wr", int'(w_wr), 1);
            if (i == 3) init_req = 1;
        end
        step();
        chk("reinit_done", int'(init_busy), 0);

        // Reset in the middle of a clearing pass
        init_req = 1;
        step();
        init_req = 0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_addr5", int'(w_addr), 5);
        rst = 0;
        step();
        chk_reset_vals("midrst");
        rst = 1;
        step();
        chk("restart_addr", int'(w_addr), 0);
        chk("restart_wr", int'(w_wr), 1);
        for (int i = 0; i < 9; i++) step();

        // Randomised traffic with held requests, occasional init_req and reset
        acc0 = 1; acc1 = 1;
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 199) != 0);
            init_req = ($urandom_range(0, 29) == 0);
            if (!req0_valid || acc0 || !rst) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr  = 3'($urandom_range(0, 7));
                req0_data  = 4'($urandom_range(0, 15));
            end
            if (!req1_valid || acc1 || !rst) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = 3'($urandom_range(0, 7));
                req1_data  = 4'($urandom_range(0, 15));
            end
            #2;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            step();
        end

        rst = 1; init_req = 0; req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 12; i++) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
